// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the PE result serializer.
package pe_pkg;

    localparam int unsigned DEFAULT_OUTPUT_WIDTH = 32;
    localparam int unsigned BYTE_BITS            = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/pe_byte_select.sv
// Combinational byte mux: picks byte byte_idx of element elem_idx from the snapshot.
module pe_byte_select
    import pe_pkg::*;
#(
    parameter int unsigned ELEMS          = 4,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned ELEM_W         = 2,
    parameter int unsigned BIDX_W         = 2
) (
    input  logic [ELEMS*BYTES_PER_WORD*BYTE_BITS-1:0] snapshot,
    input  logic [ELEM_W-1:0]                         elem_idx,
    input  logic [BIDX_W-1:0]                         byte_idx,
    output logic [BYTE_BITS-1:0]                      out_byte
);

    // Explicit mux over legal (elem, byte) pairs keeps every select in range.
    always_comb begin
        out_byte = '0;
        for (int unsigned e = 0; e < ELEMS; e++) begin
            for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
                if (elem_idx == ELEM_W'(e) && byte_idx == BIDX_W'(b)) begin
                    out_byte = snapshot[(e*BYTES_PER_WORD + b)*BYTE_BITS +: BYTE_BITS];
                end
            end
        end
    end

endmodule

// File: rtl/pe_result_serializer.sv
// Snapshots the MxN accumulator grid on start and streams it out one byte per
// valid/ready transfer, LSB-first within a word, elements in row-major order.
module pe_result_serializer
    import pe_pkg::*;
#(
    parameter int unsigned M            = 2,
    parameter int unsigned N            = 2,
    parameter int unsigned OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [M*N*OUTPUT_WIDTH-1:0] data_in,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [BYTE_BITS-1:0]        out_byte,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned BYTES_PER_WORD = OUTPUT_WIDTH / BYTE_BITS;
    localparam int unsigned ELEMS          = M * N;
    localparam int unsigned ELEM_W         = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int unsigned BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(ELEMS - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

    state_t                        state_q;
    state_t                        state_d;
    logic [M*N*OUTPUT_WIDTH-1:0]   snap_q;
    logic [ELEM_W-1:0]             elem_q;
    logic [BIDX_W-1:0]             byte_q;
    logic [BYTE_BITS-1:0]          sel_byte;
    logic                          at_last;
    logic                          xfer;

    pe_byte_select #(
        .ELEMS          (ELEMS),
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .ELEM_W         (ELEM_W),
        .BIDX_W         (BIDX_W)
    ) u_byte_select (
        .snapshot (snap_q),
        .elem_idx (elem_q),
        .byte_idx (byte_q),
        .out_byte (sel_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        out_byte  = '0;
        at_last   = (elem_q == LAST_ELEM) && (byte_q == LAST_BYTE);
        xfer      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_byte  = sel_byte;
                out_last  = at_last;
                xfer      = out_ready;
                if (out_ready && at_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture only from IDLE so a start during SEND/DONE never disturbs the held snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            elem_q <= '0;
            byte_q <= '0;
        end else if (state_q == IDLE && start) begin
            snap_q <= data_in;
            elem_q <= '0;
            byte_q <= '0;
        end else if (xfer) begin
            if (byte_q == LAST_BYTE) begin
                byte_q <= '0;
                elem_q <= (elem_q == LAST_ELEM) ? '0 : elem_q + 1'b1;
            end else begin
                byte_q <= byte_q + 1'b1;
            end
        end
    end

endmodule
